svm_seq_mac: RTL and testbench

// Sequential one-vs-one SVM evaluator that sits between the feature input and the 7-class DAG picker.
// - Per binary decision: multiply-accumulates one latched feature vector against the weight/bias pair the picker presents.
// - Uses one multiplier, one feature per cycle.
// - Returns w_class with a one-cycle svmready pulse so the picker can advance.
// - Runs exactly N_DECISIONS decisions per sample, then idles.

---
 rtl/svm_pkg.sv | 26 ++
 rtl/svm_feat_rotator.sv | 33 +++
 rtl/svm_seq_mac.sv | 138 +++++++++++++
 tb/tb_svm_seq_mac.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared definitions for the sequential SVM evaluator: FSM states,
// default datapath widths and the accumulator width rule.
package svm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        BIAS = 2'd2,
        RESP = 2'd3
    } svm_state_e;

    localparam int SVM_N_FEATURES  = 11;
    localparam int SVM_FEAT_W      = 4;
    localparam int SVM_WEIGHT_W    = 8;
    localparam int SVM_BIAS_W      = 12;
    localparam int SVM_N_DECISIONS = 6;

    // Worst-case dot product plus bias, with one guard bit so the sign is exact.
    function automatic int svm_acc_w(input int weight_w, input int feat_w,
                                     input int n_features, input int bias_w);
        int prod_sum_w;
        prod_sum_w = weight_w + feat_w + 1 + $clog2(n_features);
        return ((prod_sum_w > bias_w) ? prod_sum_w : bias_w) + 1;
    endfunction

endpackage

// File: rtl/svm_feat_rotator.sv
// Circular feature register: loads a whole sample, then rotates one slot
// per cycle so that slot 0 presents each feature in turn.
module svm_feat_rotator
    import svm_pkg::*;
#(
    parameter int N_FEATURES = SVM_N_FEATURES,
    parameter int FEAT_W     = SVM_FEAT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         rotate,
    input  logic [FEAT_W*N_FEATURES-1:0] features_in,
    output logic [FEAT_W-1:0]            slot0
);

    logic [FEAT_W-1:0] slots [N_FEATURES];

    // Load the sample, or shift slots toward 0 with slot 0 wrapping to the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_FEATURES; i++) slots[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < N_FEATURES; i++) slots[i] <= features_in[i*FEAT_W +: FEAT_W];
        end else if (rotate) begin
            for (int i = 0; i < N_FEATURES - 1; i++) slots[i] <= slots[i+1];
            slots[N_FEATURES-1] <= slots[0];
        end
    end

    assign slot0 = slots[0];

endmodule

// File: rtl/svm_seq_mac.sv
// Sequential one-vs-one SVM evaluator: one multiplier, one feature per
// cycle, one decision per N_FEATURES+2 clocks, N_DECISIONS per sample.
module svm_seq_mac
    import svm_pkg::*;
#(
    parameter int N_FEATURES  = SVM_N_FEATURES,
    parameter int FEAT_W      = SVM_FEAT_W,
    parameter int WEIGHT_W    = SVM_WEIGHT_W,
    parameter int BIAS_W      = SVM_BIAS_W,
    parameter int N_DECISIONS = SVM_N_DECISIONS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [FEAT_W*N_FEATURES-1:0]   features,
    input  logic [WEIGHT_W*N_FEATURES-1:0] weight,
    input  logic [BIAS_W-1:0]              bia,
    output logic                           svmready,
    output logic                           w_class,
    output logic                           busy,
    output logic                           done
);

    localparam int ACC_W  = svm_acc_w(WEIGHT_W, FEAT_W, N_FEATURES, BIAS_W);
    localparam int PROD_W = WEIGHT_W + FEAT_W + 1;
    localparam int CNT_W  = (N_FEATURES  > 1) ? $clog2(N_FEATURES)  : 1;
    localparam int DEC_W  = (N_DECISIONS > 1) ? $clog2(N_DECISIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_FEAT = CNT_W'(N_FEATURES - 1);
    localparam logic [DEC_W-1:0] LAST_DEC  = DEC_W'(N_DECISIONS - 1);

    svm_state_e               state;
    logic [CNT_W-1:0]         feature_cnt;
    logic [DEC_W-1:0]         dec_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [WEIGHT_W-1:0] w_arr [N_FEATURES];
    logic signed [WEIGHT_W-1:0] w_sel;
    logic [FEAT_W-1:0]        feat0;
    logic                     load_sample;

    assign load_sample = (state == IDLE) && start;
    assign busy        = (state != IDLE);

    svm_feat_rotator #(
        .N_FEATURES (N_FEATURES),
        .FEAT_W     (FEAT_W)
    ) u_rotator (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_sample),
        .rotate      (state == MAC),
        .features_in (features),
        .slot0       (feat0)
    );

    for (genvar g = 0; g < N_FEATURES; g++) begin : g_wslice
        assign w_arr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
    end

    assign w_sel = w_arr[feature_cnt];

    // Single multiplier and single adder; the adder takes the bias during BIAS.
    always_comb begin
        prod   = $signed({{(PROD_W-WEIGHT_W){w_sel[WEIGHT_W-1]}}, w_sel})
               * $signed({{(PROD_W-FEAT_W){1'b0}}, feat0});
        addend = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
        if (state == BIAS) begin
            addend = $signed({{(ACC_W-BIAS_W){bia[BIAS_W-1]}}, bia});
        end
        sum = acc + addend;
    end

    // Sequencer: IDLE -> MAC x N_FEATURES -> BIAS -> RESP -> MAC or IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            feature_cnt <= '0;
            dec_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        feature_cnt <= '0;
                        dec_cnt     <= '0;
                        state       <= MAC;
                    end
                end
                MAC: begin
                    if (feature_cnt == LAST_FEAT) begin
                        state <= BIAS;
                    end else begin
                        feature_cnt <= feature_cnt + 1'b1;
                    end
                end
                BIAS: state <= RESP;
                RESP: begin
                    if (dec_cnt == LAST_DEC) begin
                        state <= IDLE;
                    end else begin
                        dec_cnt     <= dec_cnt + 1'b1;
                        feature_cnt <= '0;
                        state       <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accumulator: cleared at the start of every decision, summed in MAC and BIAS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load_sample || (state == RESP)) begin
            acc <= '0;
        end else if ((state == MAC) || (state == BIAS)) begin
            acc <= sum;
        end
    end

    // Registered handshake: decision and ready pulse land together in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svmready <= 1'b0;
            done     <= 1'b0;
            w_class  <= 1'b0;
        end else begin
            svmready <= (state == BIAS);
            done     <= (state == BIAS) && (dec_cnt == LAST_DEC);
            if (state == BIAS) begin
                w_class <= sum[ACC_W-1] || (sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_svm_seq_mac.sv
// Randomized bench for svm_seq_mac with a plain-arithmetic decision model.
module tb_svm_seq_mac;

    localparam int NF     = 11;
    localparam int FW     = 4;
    localparam int WW     = 8;
    localparam int BW     = 12;
    localparam int ND     = 6;
    localparam int PERIOD = NF + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NF*FW-1:0]  features = '0;
    logic [NF*WW-1:0]  weight = '0;
    logic [BW-1:0]     bia = '0;
    logic              svmready;
    logic              w_class;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    int feat_ref [NF];
    int w_tab [ND][NF];
    int b_tab [ND];

    svm_seq_mac dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .features (features),
        .weight   (weight),
        .bia      (bia),
        .svmready (svmready),
        .w_class  (w_class),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decision rule: first class wins only when w.f + b is strictly positive.
    function automatic int ref_wclass(input int d);
        int s;
        s = b_tab[d];
        for (int i = 0; i < NF; i++) s += w_tab[d][i] * feat_ref[i];
        return (s <= 0) ? 1 : 0;
    endfunction

    task automatic drive_picker(input int d);
        int tmp;
        tmp = b_tab[d];
        bia = tmp[BW-1:0];
        for (int i = 0; i < NF; i++) begin
            tmp = w_tab[d][i];
            weight[i*WW +: WW] = tmp[WW-1:0];
        end
    endtask

    task automatic load_features();
        int tmp;
        for (int i = 0; i < NF; i++) begin
            tmp = feat_ref[i];
            features[i*FW +: FW] = tmp[FW-1:0];
        end
    endtask

    task automatic fill_const(input int fv, input int wv, input int bv);
        for (int i = 0; i < NF; i++) feat_ref[i] = fv;
        for (int d = 0; d < ND; d++) begin
            b_tab[d] = bv;
            for (int i = 0; i < NF; i++) w_tab[d][i] = wv;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NF; i++) feat_ref[i] = int'($urandom_range(15));
        for (int d = 0; d < ND; d++) begin
            b_tab[d] = int'($urandom_range(4095)) - 2048;
            for (int i = 0; i < NF; i++) w_tab[d][i] = int'($urandom_range(255)) - 128;
        end
    endtask

    // One full sample; optionally pokes start mid-MAC, aborts with reset,
    // or holds start high during the final RESP cycle.
    task automatic run_sample(input int inject_dec, input int abort_dec, input int start_last_resp);
        int cyc;
        int dec_start;
        int waited;
        load_features();
        drive_picker(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check("busy_after_start", busy, 1);
        for (int d = 0; d < ND; d++) begin
            dec_start = cyc;
            waited = 0;
            while (!svmready && waited < 2*PERIOD) begin
                if (d == inject_dec && cyc == dec_start + 2) begin
                    features = ~features;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (d == abort_dec && cyc == dec_start + 4) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("abort_svmready", svmready, 0);
                    check("abort_w_class", w_class, 0);
                    check("abort_done", done, 0);
                    check("abort_busy", busy, 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    check("abort_idle", busy, 0);
                    return;
                end
                @(negedge clk);
                cyc++;
                waited++;
            end
            start = 1'b0;
            if (!svmready) begin
                check("ready_timeout", 0, 1);
                return;
            end
            check("ready_cycle", cyc, PERIOD - 1 + PERIOD*d);
            check("w_class", w_class, ref_wclass(d));
            check("done", done, (d == ND-1) ? 1 : 0);
            if (d < ND-1) begin
                drive_picker(d + 1);
                @(negedge clk);
                cyc++;
                check("ready_pulse_width", svmready, 0);
            end else if (start_last_resp != 0) begin
                start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("end_svmready", svmready, 0);
        check("end_done", done, 0);
        check("end_busy", busy, 0);
        check("w_class_hold", w_class, ref_wclass(ND-1));
    endtask

    initial begin
        #1;
        check("rst_svmready", svmready, 0);
        check("rst_w_class", w_class, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero features, positive bias: every decision goes to the first class.
        fill_rand();
        fill_const(0, 0, 5);
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < NF; i++) w_tab[d][i] = int'($urandom_range(255)) - 128;
        run_sample(-1, -1, 0);

        fill_const(15, -1, 0);
        run_sample(-1, -1, 0);

        fill_const(1, 1, -11);
        run_sample(-1, -1, 0);

        fill_const(15, -128, -2048);
        run_sample(-1, -1, 0);

        fill_const(15, 127, 2047);
        run_sample(-1, -1, 0);

        for (int k = 0; k < 4; k++) begin
            fill_rand();
            run_sample(-1, -1, (k == 1) ? 1 : 0);
        end

        // start during decision 3 must not disturb the sample in flight.
        fill_rand();
        run_sample(3, -1, 0);

        // Reset in the middle of decision 2, then a clean sample.
        fill_rand();
        run_sample(-1, 2, 0);
        fill_rand();
        run_sample(-1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
